spi_mmio: RTL
=============

# spi_mmio

Memory-mapped SPI master peripheral on the SOC data bus, a sibling of the GPIO and UART MMIO slaves. It sits downstream of the CPU's memory port and upstream of the SOC read-data multiplexer. Software writes a byte and polls a status register; the block shifts the byte out on MOSI while shifting one in from MISO (SPI mode 0, MSB first). It is the first step toward external SPI flash.

## Interface
- BASE_MEMORY, 32'hFFFF_FFF8, first byte address decoded (DATA register)
- TOP_MEMORY, 32'hFFFF_FFFF, last byte address decoded; CTRL register at BASE_MEMORY+4
- CLK_DIVIDER, 1, SCLK half-period in slowed_clk cycles; legal range 1..255
- slowed_clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high
- memAddress  in  32  CPU byte address
- memWriteData  in  32  CPU write data
- memWrite  in  1  write strobe, sampled each rising edge
- byteMask  in  4  byte enables; only bit 0 is used
- memReadData  out  32  registered read data
- spi_sclk  out  1  serial clock, idles low
- spi_mosi  out  1  master out
- spi_miso  in  1  master in, sampled on SCLK rising edge
- spi_cs_n  out  1  chip select, software-controlled

## Operation
- Decode: a register is hit when BASE_MEMORY <= memAddress <= TOP_MEMORY; offset = memAddress[2]. Writes outside this range are ignored.
- DATA (offset 0):
  - Write with byteMask[0]=1 while idle: loads memWriteData[7:0] into tx shift register, clears rx_valid, starts a transfer.
  - Write while busy: ignored; sets overrun.
  - Read: {24'b0, rx_data}.
- CTRL/STATUS (offset 4). Read value is {26'b0, 2'b0 reserved…} with:
  - bit0 busy (RO)
  - bit1 rx_valid (RO)
  - bit2 cs_n (RW)
  - bit3 overrun (RO; writing 1 clears it)
  - other bits read 0
- CTRL write with byteMask[0]=1: cs_n <= memWriteData[2]; if memWriteData[3], overrun <= 0. Legal mid-transfer; takes effect next edge.
- Reads have no side effects. The CPU holds an address across several cycles, so repeated reads are safe.
- FSM states IDLE, LOW, HIGH; a div counter counts 0..CLK_DIVIDER-1; a bit counter counts 0..7.
  - IDLE -> LOW on start: mosi <= tx[7], sclk=0, counters cleared, busy=1.
  - LOW -> HIGH when div counter hits CLK_DIVIDER-1: sclk <= 1, rx <= {rx[6:0], spi_miso}.
  - HIGH -> LOW when div counter hits CLK_DIVIDER-1 and bit counter < 7: sclk <= 0, shift tx, mosi <= next bit, bit counter +1.
  - HIGH -> IDLE when div counter hits CLK_DIVIDER-1 and bit counter == 7: sclk <= 0, rx_data <= rx, rx_valid <= 1, busy <= 0.
- Simultaneous CTRL and DATA writes are impossible (one address per cycle).
- A DATA write on the same edge that busy falls is treated as busy: it is ignored and overrun is set.

## Timing
- Reset values: memReadData 0, spi_sclk 0, spi_mosi 0, spi_cs_n 1, busy 0, rx_valid 0, overrun 0, rx_data 0, FSM IDLE.
- Reset mid-transfer aborts immediately, with no partial rx_data update.
- Read latency is 1 cycle. memReadData at edge N+1 reflects the register addressed at edge N, which matches the SOC's delayed-address mux. Out-of-range address gives memReadData 0.
- For a DATA write sampled at edge N:
  - busy=1 from N.
  - SCLK rises at N+(2k+1)·D and falls at N+(2k+2)·D, for k=0..7.
  - busy=0 and rx_valid=1 at N+16·D.
  - A STATUS read issued at N+16·D returns busy=0.
- MOSI changes only on SCLK falling edges or at transfer start, and is stable for a full SCLK high phase.

## Structure
- spi_pkg: state enum (IDLE, LOW, HIGH), register offsets, CTRL bit positions (BUSY=0, RXV=1, CSN=2, OVR=3).
- Sub-module spi_shifter: FSM, divider, shift registers and pins. Interface: start, tx_byte, busy, done, rx_byte.
- spi_mmio: decode, CTRL/status flags, read register.

## Test plan
- Reset: assert reset -> all outputs match reset values; STATUS read = 32'h0000_0004.
- Loopback (miso tied to mosi, D=1): write DATA 32'h0000_00A5 -> 8 SCLK pulses, busy high 16 cycles; then DATA read = 32'h0000_00A5 and STATUS = 32'h0000_0006 (cs_n still 1).
- MISO held 1, D=2: write 32'h0000_0000 -> MOSI stays 0, busy 32 cycles, DATA read = 32'h0000_00FF.
- Write DATA 32'h0000_0011 at cycle 3 of an active transfer -> transfer unaffected, STATUS bit3=1; CTRL write 32'h0000_000C -> overrun 0, cs_n 1.
- CTRL write 32'h0000_0000 -> spi_cs_n 0 next edge. Write with byteMask=4'b0010 -> no change. Write to 32'h0000_0100 -> no register change; read there via this block returns 0.
- Async reset at cycle 7 of a transfer -> sclk 0, cs_n 1, busy 0, rx_valid 0, rx_data 0 immediately.

Source files
------------

// File: rtl/spi_mmio_pkg.sv
// Shared constants, FSM state type and status-word packing for the SPI MMIO master.
package spi_mmio_pkg;

  localparam logic [31:0] BASE_MEMORY = 32'hFFFF_FFF8;
  localparam logic [31:0] TOP_MEMORY  = 32'hFFFF_FFFF;
  // The decoded window is one aligned 8-byte block, so a mask compare covers it.
  localparam logic [31:0] ADDR_MASK   = ~(TOP_MEMORY ^ BASE_MEMORY);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 3;

  // Register select is memAddress[2].
  localparam logic OFF_DATA = 1'b0;
  localparam logic OFF_CTRL = 1'b1;

  // CTRL/STATUS bit positions.
  localparam int unsigned CTRL_BUSY = 0;
  localparam int unsigned CTRL_RXV  = 1;
  localparam int unsigned CTRL_CSN  = 2;
  localparam int unsigned CTRL_OVR  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_e;

  // Pack the status flags into the 32-bit STATUS read value; unused bits read 0.
  function automatic logic [31:0] status_word(input logic busy, input logic rxv,
                                              input logic csn, input logic ovr);
    logic [31:0] w;
    w            = '0;
    w[CTRL_BUSY] = busy;
    w[CTRL_RXV]  = rxv;
    w[CTRL_CSN]  = csn;
    w[CTRL_OVR]  = ovr;
    return w;
  endfunction

endpackage

// File: rtl/spi_mmio_shifter.sv
// SPI mode-0 byte shifter: SCLK divider, bit sequencing, MOSI/MISO shift registers.
module spi_mmio_shifter
  import spi_mmio_pkg::*;
#(
  parameter int unsigned CLK_DIVIDER = 1
) (
  input  logic              slowed_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_byte,
  input  logic              spi_miso,
  output logic              busy,
  output logic              done_c,
  output logic [DATA_W-1:0] rx_byte,
  output logic              spi_sclk,
  output logic              spi_mosi
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIVIDER - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              div_hit;

  assign div_hit  = (div_q == DIV_LAST);
  assign busy     = busy_q;
  assign rx_byte  = rx_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

  // Next-state logic: half-period divider, then toggle SCLK and shift.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOW;
          tx_d    = tx_byte;
          mosi_d  = tx_byte[DATA_W-1];
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
        end
      end
      LOW: begin
        if (div_hit) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], spi_miso};
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HIGH: begin
        if (div_hit) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q != BIT_LAST) begin
            state_d = LOW;
            tx_d    = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_q[DATA_W-2];
            bit_d   = bit_q + BIT_W'(1);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_c  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // State and pin registers; reset aborts any transfer immediately.
  always_ff @(posedge slowed_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/spi_mmio.sv
// Memory-mapped SPI master: address decode, CTRL/STATUS flags, registered read data.
module spi_mmio
  import spi_mmio_pkg::*;
#(
  parameter int unsigned CLK_DIVIDER = 1
) (
  input  logic        slowed_clk,
  input  logic        reset,
  input  logic [31:0] memAddress,
  input  logic [31:0] memWriteData,
  input  logic        memWrite,
  input  logic [3:0]  byteMask,
  output logic [31:0] memReadData,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  logic              hit_c, off_c, wr_c, data_wr_c, ctrl_wr_c, start_c;
  logic              busy, done_c;
  logic [DATA_W-1:0] rx_byte;
  logic              unused_bits;

  logic              cs_n_q, cs_n_d;
  logic              ovr_q, ovr_d;
  logic              rxv_q, rxv_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [31:0]       rd_q, rd_d;

  assign hit_c     = ((memAddress & ADDR_MASK) == BASE_MEMORY);
  assign off_c     = memAddress[2];
  assign wr_c      = memWrite & hit_c & byteMask[0];
  assign data_wr_c = wr_c & (off_c == OFF_DATA);
  assign ctrl_wr_c = wr_c & (off_c == OFF_CTRL);
  // A DATA write on the edge busy falls still sees busy=1 and is rejected.
  assign start_c   = data_wr_c & ~busy;
  assign unused_bits = ^{memWriteData[31:DATA_W], byteMask[3:1]};

  assign memReadData = rd_q;
  assign spi_cs_n    = cs_n_q;

  spi_mmio_shifter #(
    .CLK_DIVIDER(CLK_DIVIDER)
  ) u_shifter (
    .slowed_clk(slowed_clk),
    .reset     (reset),
    .start     (start_c),
    .tx_byte   (memWriteData[DATA_W-1:0]),
    .spi_miso  (spi_miso),
    .busy      (busy),
    .done_c    (done_c),
    .rx_byte   (rx_byte),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi)
  );

  // Flag updates and read mux; reads sample current register values only.
  always_comb begin
    cs_n_d    = cs_n_q;
    ovr_d     = ovr_q;
    rxv_d     = rxv_q;
    rx_data_d = rx_data_q;
    rd_d      = '0;
    if (start_c) begin
      rxv_d = 1'b0;
    end
    if (done_c) begin
      rxv_d     = 1'b1;
      rx_data_d = rx_byte;
    end
    if (data_wr_c && busy) begin
      ovr_d = 1'b1;
    end
    if (ctrl_wr_c) begin
      cs_n_d = memWriteData[CTRL_CSN];
      if (memWriteData[CTRL_OVR]) begin
        ovr_d = 1'b0;
      end
    end
    if (hit_c) begin
      if (off_c == OFF_CTRL) begin
        rd_d = status_word(busy, rxv_q, cs_n_q, ovr_q);
      end else begin
        rd_d = 32'(rx_data_q);
      end
    end
  end

  // Register file and read-data register.
  always_ff @(posedge slowed_clk or posedge reset) begin
    if (reset) begin
      cs_n_q    <= 1'b1;
      ovr_q     <= 1'b0;
      rxv_q     <= 1'b0;
      rx_data_q <= '0;
      rd_q      <= '0;
    end else begin
      cs_n_q    <= cs_n_d;
      ovr_q     <= ovr_d;
      rxv_q     <= rxv_d;
      rx_data_q <= rx_data_d;
      rd_q      <= rd_d;
    end
  end

endmodule
